uart_rx_deframer: RTL

- UART receive front end inside chip_top. Deframes the serial `rx` pin into bytes for the edge-detection pixel pipeline.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Bit time is `CLKS_PER_BIT` clocks; the chip bench uses 320 ns bits on a 10 ns clock, so 32.
- Output is one holding register with a valid/ready handshake to the pixel consumer, plus framing-error and overrun flags.

---
 rtl/uart_rx_deframer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - UART 8N1 receive deframer with valid/ready holding register
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at every sample point.
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // Decision lands one clock after the nominal mid-bit so all three votes are in.
    localparam logic [CW-1:0] CNT_MID = CW'(H);
`else
    localparam logic [CW-1:0] CNT_MID = CW'(H - 1);
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_prev;
    logic                   sample;
    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign busy = (state != ST_IDLE);

`ifdef UART_RX_MAJORITY_EN
    logic rxs_prev2;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rxs_prev2 <= 1'b1;
        end else begin
            rxs_prev2 <= rxs_prev;
        end
    end

    always_comb begin
        sample = (rxs & rxs_prev) | (rxs & rxs_prev2) | (rxs_prev & rxs_prev2);
    end
`else
    always_comb begin
        sample = rxs;
    end
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_q   <= '1;
            rxs_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rx};
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rxs_prev && !rxs) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_MID) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= sample ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= sample;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start.
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (!sample) begin
                            frame_err <= 1'b1;
                        end else if (!rx_valid || rx_ready) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
